// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, bubble encoding, PC step and default widths.
// Also intended for use by the IF/ID register and the hazard logic.
package if_fetch_unit_pkg;

    localparam int          XLEN_DEFAULT     = 64;
    localparam int          INST_W_DEFAULT   = 32;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam int          PC_INCR          = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer for
// stalls, and branch redirect that discards in-flight or buffered fetches.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                XLEN     = XLEN_DEFAULT,
    parameter int                INST_W   = INST_W_DEFAULT,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [XLEN-1:0]   pc_out,
    output logic [INST_W-1:0] instruction,
    output logic              if_valid
);

    fetch_state_e      state_reg, state_next;
    logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]   hold_pc_reg, hold_pc_next;
    logic [INST_W-1:0] hold_inst_reg, hold_inst_next;
    logic [XLEN-1:0]   pc_out_reg, pc_out_next;
    logic [INST_W-1:0] inst_reg, inst_next;
    logic              valid_reg, valid_next;

    logic              deliver;
    logic [XLEN-1:0]   deliver_pc;
    logic [INST_W-1:0] deliver_inst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            fetch_pc_reg  <= RESET_PC;
            hold_pc_reg   <= '0;
            hold_inst_reg <= '0;
            pc_out_reg    <= '0;
            inst_reg      <= NOP_INST;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            hold_pc_reg   <= hold_pc_next;
            hold_inst_reg <= hold_inst_next;
            pc_out_reg    <= pc_out_next;
            inst_reg      <= inst_next;
            valid_reg     <= valid_next;
        end
    end

    // Next state, fetch PC, hold buffer and the instruction to deliver (if any).
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        hold_pc_next   = hold_pc_reg;
        hold_inst_next = hold_inst_reg;
        deliver        = 1'b0;
        deliver_pc     = fetch_pc_reg;
        deliver_inst   = imem_rdata;
        unique case (state_reg)
            S_IDLE: begin
                if (branch_taken) begin
                    fetch_pc_next = branch_target;
                end else if (imem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    fetch_pc_next = branch_target;
                    state_next    = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    if (!stall) begin
                        deliver       = 1'b1;
                        fetch_pc_next = fetch_pc_reg + XLEN'(PC_INCR);
                        state_next    = S_IDLE;
                    end else begin
                        hold_pc_next   = fetch_pc_reg;
                        hold_inst_next = imem_rdata;
                        state_next     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    fetch_pc_next = branch_target;
                    state_next    = S_IDLE;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_pc    = hold_pc_reg;
                    deliver_inst  = hold_inst_reg;
                    fetch_pc_next = fetch_pc_reg + XLEN'(PC_INCR);
                    state_next    = S_IDLE;
                end
            end
            S_DROP: begin
                // A redirect here only retargets; the stale response is still owed.
                if (branch_taken) begin
                    fetch_pc_next = branch_target;
                end
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output register: flush beats stall, stall beats delivery, otherwise bubble.
    always_comb begin
        pc_out_next = pc_out_reg;
        inst_next   = inst_reg;
        valid_next  = valid_reg;
        if (branch_taken) begin
            inst_next  = NOP_INST;
            valid_next = 1'b0;
        end else if (stall) begin
            pc_out_next = pc_out_reg;
        end else if (deliver) begin
            pc_out_next = deliver_pc;
            inst_next   = deliver_inst;
            valid_next  = 1'b1;
        end else begin
            inst_next  = NOP_INST;
            valid_next = 1'b0;
        end
    end

    always_comb begin
        imem_req  = (state_reg == S_IDLE) && !branch_taken;
        imem_addr = fetch_pc_reg;
    end

    assign pc_out      = pc_out_reg;
    assign instruction = inst_reg;
    assign if_valid    = valid_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus an async-reset sequence.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] pc_out;
    logic [31:0] instruction;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .if_valid     (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bt;
        logic [63:0] tgt;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(logic s, logic b, logic [63:0] t, logic r, logic rv,
                                logic [31:0] d, logic er, logic [63:0] ea,
                                logic [63:0] ep, logic [31:0] ei, logic ev);
        vec_t v;
        v.stall = s; v.bt = b; v.tgt = t; v.ready = r; v.rvalid = rv; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_pc = ep; v.e_inst = ei; v.e_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [63:0] t,
                         input logic r, input logic rv, input logic [31:0] d);
        stall = s; branch_taken = b; branch_target = t;
        imem_ready = r; imem_rvalid = rv; imem_rdata = d;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.stall, v.bt, v.tgt, v.ready, v.rvalid, v.rdata);
        #1;
        check($sformatf("v%0d imem_req", idx), 64'(imem_req), 64'(v.e_req));
        check($sformatf("v%0d imem_addr", idx), imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        check($sformatf("v%0d pc_out", idx), pc_out, v.e_pc);
        check($sformatf("v%0d instruction", idx), 64'(instruction), 64'(v.e_inst));
        check($sformatf("v%0d if_valid", idx), 64'(if_valid), 64'(v.e_valid));
        $display("vec %0d: req=%b addr=%h pc_out=%h inst=%h valid=%b",
                 idx, v.e_req, v.e_addr, pc_out, instruction, if_valid);
    endtask

    initial begin
        //            stall bt tgt         rdy rv rdata         req addr        pc          inst          valid
        vecs[0]  = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h0,      64'h0,      NOP,          0);
        vecs[1]  = mk(0, 0, 64'h0,      1, 1, 32'hA0,      0, 64'h0,      64'h0,      32'hA0,       1);
        vecs[2]  = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h4,      64'h0,      NOP,          0);
        vecs[3]  = mk(0, 0, 64'h0,      1, 1, 32'hA4,      0, 64'h4,      64'h4,      32'hA4,       1);
        vecs[4]  = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h8,      64'h4,      NOP,          0);
        // response for PC 8 arrives under stall, stall held 3 cycles
        vecs[5]  = mk(1, 0, 64'h0,      1, 1, 32'h1234,    0, 64'h8,      64'h4,      NOP,          0);
        vecs[6]  = mk(1, 0, 64'h0,      1, 0, 32'h0,       0, 64'h8,      64'h4,      NOP,          0);
        vecs[7]  = mk(1, 0, 64'h0,      1, 0, 32'h0,       0, 64'h8,      64'h4,      NOP,          0);
        vecs[8]  = mk(0, 0, 64'h0,      1, 0, 32'h0,       0, 64'h8,      64'h8,      32'h1234,     1);
        vecs[9]  = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'hC,      64'h8,      NOP,          0);
        // redirect while waiting, late response must be discarded
        vecs[10] = mk(0, 1, 64'h100,    1, 0, 32'h0,       0, 64'hC,      64'h8,      NOP,          0);
        vecs[11] = mk(0, 0, 64'h0,      1, 1, 32'hDEAD,    0, 64'h100,    64'h8,      NOP,          0);
        vecs[12] = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h100,    64'h8,      NOP,          0);
        // redirect in the same cycle as the response
        vecs[13] = mk(0, 1, 64'h200,    1, 1, 32'h5555,    0, 64'h100,    64'h8,      NOP,          0);
        vecs[14] = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h200,    64'h8,      NOP,          0);
        vecs[15] = mk(0, 0, 64'h0,      1, 1, 32'h7777,    0, 64'h200,    64'h200,    32'h7777,     1);
        // stall keeps a valid output, then redirect from HOLD flushes it despite stall
        vecs[16] = mk(1, 0, 64'h0,      1, 0, 32'h0,       1, 64'h204,    64'h200,    32'h7777,     1);
        vecs[17] = mk(1, 0, 64'h0,      1, 1, 32'h8888,    0, 64'h204,    64'h200,    32'h7777,     1);
        vecs[18] = mk(1, 1, 64'h300,    1, 0, 32'h0,       0, 64'h204,    64'h200,    NOP,          0);
        vecs[19] = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h300,    64'h200,    NOP,          0);
        vecs[20] = mk(0, 0, 64'h0,      1, 1, 32'h9999,    0, 64'h300,    64'h300,    32'h9999,     1);
        // redirect in IDLE suppresses the request
        vecs[21] = mk(0, 1, 64'h400,    1, 0, 32'h0,       0, 64'h304,    64'h300,    NOP,          0);
        vecs[22] = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'h400,    64'h300,    NOP,          0);
        vecs[23] = mk(0, 0, 64'h0,      1, 1, 32'hABCD,    0, 64'h400,    64'h400,    32'hABCD,     1);
        // PC wraps from the top of the address space
        vecs[24] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 32'h0, 0, 64'h404, 64'h400, NOP,    0);
        vecs[25] = mk(0, 0, 64'h0,      1, 0, 32'h0,       1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h400, NOP, 0);
        vecs[26] = mk(0, 0, 64'h0,      1, 1, 32'h1111,    0, 64'hFFFF_FFFF_FFFF_FFFC,
                      64'hFFFF_FFFF_FFFF_FFFC, 32'h1111, 1);
        // stray rvalid in IDLE with no ready: ignored, request stays up
        vecs[27] = mk(0, 0, 64'h0,      0, 1, 32'hBAD0,    1, 64'h0,
                      64'hFFFF_FFFF_FFFF_FFFC, NOP, 0);

        reset = 1'b0;
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        #12;
        check("reset pc_out", pc_out, 64'h0);
        check("reset instruction", 64'(instruction), 64'(NOP));
        check("reset if_valid", 64'(if_valid), 64'h0);
        check("reset imem_addr", imem_addr, 64'h0);
        check("reset imem_req", 64'(imem_req), 64'h1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) apply(vecs[i], i);

        // Deliver at PC 0, then stall with a request in flight.
        apply(mk(0, 0, 64'h0, 1, 0, 32'h0,    1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, NOP, 0), 100);
        apply(mk(0, 0, 64'h0, 1, 1, 32'h2222, 0, 64'h0, 64'h0, 32'h2222, 1), 101);
        apply(mk(1, 0, 64'h0, 1, 0, 32'h0,    1, 64'h4, 64'h0, 32'h2222, 1), 102);

        // Asynchronous reset in the middle of WAIT takes effect immediately.
        @(negedge clk);
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async instruction", 64'(instruction), 64'(NOP));
        check("async if_valid", 64'(if_valid), 64'h0);
        check("async imem_addr", imem_addr, 64'h0);
        check("async imem_req", 64'(imem_req), 64'h1);
        $display("async reset: pc_out=%h inst=%h valid=%b addr=%h", pc_out, instruction, if_valid, imem_addr);
        @(negedge clk);
        reset = 1'b1;

        // Late response after reset is ignored; first request is to the reset PC.
        apply(mk(0, 0, 64'h0, 0, 1, 32'hBAD1, 1, 64'h0, 64'h0, NOP, 0), 103);
        apply(mk(0, 0, 64'h0, 1, 0, 32'h0,    1, 64'h0, 64'h0, NOP, 0), 104);
        apply(mk(0, 0, 64'h0, 1, 1, 32'h3333, 0, 64'h0, 64'h0, 32'h3333, 1), 105);
        apply(mk(0, 0, 64'h0, 0, 0, 32'h0,    1, 64'h4, 64'h0, NOP, 0), 106);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
